// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//   Boot-time loader and fetch controller for the CPU's instruction memory.
//   After reset the controller owns the memory. It assembles big-endian
//   32-bit words from a valid/ready byte stream and writes them in order.
//   A correctly terminated program hands the memory to the CPU fetch port
//   and raises cpu_run. A misaligned or overflowing stream ends in a sticky
//   error state, which only reset clears.
//
//   Optional feature macro: IMEM_LOAD_CHECKSUM_EN
//     When defined, the ld_last byte is followed by one XOR checksum byte.
//     That byte must match the XOR of every program byte before the CPU is
//     released.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   ld_valid    loader byte valid
//   ld_ready    controller accepts a byte this cycle (LOAD / CHK only)
//   ld_byte     program byte; the first byte of a word lands in [31:24]
//   ld_last     marks the final program byte
//   pc          CPU fetch index in words
//   inst        fetched instruction; zero-latency combinational read
//   cpu_run     CPU may execute
//   load_err    load failed; sticky until reset
//   word_count  number of words written
module imem_load_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  input  logic [31:0]   pc,
  output logic [31:0]   inst,
  output logic          cpu_run,
  output logic          load_err,
  output logic [AW:0]   word_count
);

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_ERR, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_ERR} state_t;
`endif

  localparam logic [AW:0] W_FULL = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_bcnt;
  logic [23:0]   r_shift;
  logic [AW:0]   r_wcnt;
  logic [31:0]   r_mem [DEPTH];
  logic          w_accept;
  logic          w_wr;
  logic [31:0]   w_wcnt_ext;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  // ld_ready depends only on state, never on ld_valid.
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign ld_ready = (r_state == S_LOAD) || (r_state == S_CHK);
`else
  assign ld_ready = (r_state == S_LOAD);
`endif
  // Gating with rst lets reset dominate: no byte is taken and nothing is
  // written on a reset edge.
  assign w_accept   = ld_valid & ld_ready & rst;
  assign cpu_run    = (r_state == S_RUN);
  assign load_err   = (r_state == S_ERR);
  assign word_count = r_wcnt;
  assign w_wcnt_ext = 32'(r_wcnt);

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (r_wcnt == W_FULL) begin
            w_state_nxt = S_ERR;              // overflow
          end else if (r_bcnt == 2'd3) begin
            w_wr = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (ld_last) w_state_nxt = S_CHK;
`else
            if (ld_last) w_state_nxt = S_RUN;
`endif
          end else if (ld_last) begin
            w_state_nxt = S_ERR;              // program ends mid-word
          end
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHK: begin
        // ld_last is ignored on the checksum byte.
        if (w_accept) w_state_nxt = (ld_byte == r_csum) ? S_RUN : S_ERR;
      end
`endif
      default: ;
    endcase
  end

  // Fetch path: reads are gated by word_count, so memory contents left over
  // from before the reset are never visible. pc >= DEPTH always fails the
  // compare.
  always_comb begin
    inst = 32'h0;
    if ((r_state == S_RUN) && (pc < w_wcnt_ext)) inst = r_mem[pc[AW-1:0]];
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_LOAD;
      r_bcnt  <= 2'd0;
      r_wcnt  <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      r_csum  <= 8'h0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && (r_state == S_LOAD)) begin
        r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        r_csum <= r_csum ^ ld_byte;
`endif
      end
      if (w_wr) r_wcnt <= r_wcnt + 1'b1;
    end
  end

  // Datapath: the byte assembly register and the memory have no reset.
  always_ff @(posedge clk) begin
    if (w_accept && (r_state == S_LOAD)) r_shift <= {r_shift[15:0], ld_byte};
    if (w_wr) r_mem[r_wcnt[AW-1:0]] <= {r_shift, ld_byte};
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        cpu_run;
  logic        load_err;
  logic [4:0]  word_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  tb_csum;
  logic [7:0]  prog8 [8];

  imem_load_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_byte(ld_byte), .ld_last(ld_last), .pc(pc), .inst(inst),
    .cpu_run(cpu_run), .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_q.push_back(val);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h required none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h required %h", t, obs, e);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h0;
    tick();
    rst = 1'b1;
    tb_csum = 8'h0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'hxx;
    tb_csum = tb_csum ^ b;
  endtask

  task automatic finish_load();
`ifdef IMEM_LOAD_CHECKSUM_EN
    send(tb_csum, 1'b0);
`endif
  endtask

  task automatic fetch(input string tag, input logic [31:0] p, input logic [31:0] v);
    pc = p;
    #1;
    expect_v(tag, v);
    check(inst);
  endtask

  initial begin
    prog8 = '{8'h20, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h10, 8'h20};
    pc = 32'h0;
    rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h0;
    tb_csum = 8'h0;
    tick();
    tick();

    expect_v("rst_ld_ready", 32'd1);   check(32'(ld_ready));
    expect_v("rst_cpu_run", 32'd0);    check(32'(cpu_run));
    expect_v("rst_load_err", 32'd0);   check(32'(load_err));
    expect_v("rst_word_count", 32'd0); check(32'(word_count));
    expect_v("rst_inst", 32'd0);       check(inst);

    // Back-to-back 2-word program
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(prog8[i], i == 7);
      if (i == 3) begin
        expect_v("b2b_wc_after_word0", 32'd1); check(32'(word_count));
      end
    end
    finish_load();
    expect_v("b2b_cpu_run", 32'd1);    check(32'(cpu_run));
    expect_v("b2b_ld_ready", 32'd0);   check(32'(ld_ready));
    expect_v("b2b_word_count", 32'd2); check(32'(word_count));
    fetch("b2b_pc0", 32'd0, 32'h20010001);
    fetch("b2b_pc1", 32'd1, 32'h00011020);
    fetch("b2b_pc2", 32'd2, 32'h00000000);
    fetch("b2b_pc40", 32'd40, 32'h00000000);
    // ld_valid ignored in RUN
    send(8'hFF, 1'b1);
    expect_v("run_ignore_wc", 32'd2); check(32'(word_count));
    expect_v("run_ignore_run", 32'd1); check(32'(cpu_run));

    // Same program with 3-cycle gaps
    do_reset();
    pc = 32'd0;
    for (int i = 0; i < 8; i++) begin
      send(prog8[i], i == 7);
      if (i != 7) begin
        for (int g = 0; g < 3; g++) begin
          expect_v("gap_inst", 32'd0);    check(inst);
          expect_v("gap_cpu_run", 32'd0); check(32'(cpu_run));
          tick();
        end
      end
    end
    finish_load();
    expect_v("gap_cpu_run_end", 32'd1); check(32'(cpu_run));
    expect_v("gap_word_count", 32'd2);  check(32'(word_count));
    fetch("gap_pc0", 32'd0, 32'h20010001);
    fetch("gap_pc1", 32'd1, 32'h00011020);
    fetch("gap_pc2", 32'd2, 32'h00000000);

    // ld_last on the 3rd byte
    do_reset();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    expect_v("mis_load_err", 32'd1);   check(32'(load_err));
    expect_v("mis_ld_ready", 32'd0);   check(32'(ld_ready));
    expect_v("mis_cpu_run", 32'd0);    check(32'(cpu_run));
    expect_v("mis_word_count", 32'd0); check(32'(word_count));
    tick();
    expect_v("mis_sticky", 32'd1);     check(32'(load_err));

    // 16 full words, then one overflow byte
    do_reset();
    for (int k = 0; k < 16; k++) begin
      send(8'(k), 1'b0);
      send(8'(k) ^ 8'hA5, 1'b0);
      send(8'h5A, 1'b0);
      send(~8'(k), 1'b0);
    end
    expect_v("ovf_word_count", 32'd16); check(32'(word_count));
    expect_v("ovf_pre_err", 32'd0);     check(32'(load_err));
    send(8'h77, 1'b0);
    expect_v("ovf_load_err", 32'd1);    check(32'(load_err));
    expect_v("ovf_ld_ready", 32'd0);    check(32'(ld_ready));
    expect_v("ovf_cpu_run", 32'd0);     check(32'(cpu_run));
    for (int p = 0; p < 17; p++) fetch("ovf_inst", 32'(p), 32'h0);

    // Reset mid-load, then a fresh 1-word all-zero program
    do_reset();
    for (int i = 0; i < 6; i++) send(8'hC0 + 8'(i), 1'b0);
    do_reset();
    expect_v("mid_rst_wc", 32'd0); check(32'(word_count));
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    finish_load();
    expect_v("mid_word_count", 32'd1); check(32'(word_count));
    expect_v("mid_cpu_run", 32'd1);    check(32'(cpu_run));
    fetch("mid_pc0", 32'd0, 32'h0);
    fetch("mid_pc1", 32'd1, 32'h0);

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Checksum accepted
    do_reset();
    for (int i = 0; i < 8; i++) send(8'(i + 1), i == 7);
    expect_v("chk_wait_run", 32'd0);   check(32'(cpu_run));
    expect_v("chk_wait_ready", 32'd1); check(32'(ld_ready));
    send(8'h08, 1'b0);
    expect_v("chk_ok_run", 32'd1);     check(32'(cpu_run));
    fetch("chk_pc0", 32'd0, 32'h01020304);
    fetch("chk_pc1", 32'd1, 32'h05060708);
    // Checksum rejected
    do_reset();
    for (int i = 0; i < 8; i++) send(8'(i + 1), i == 7);
    send(8'h09, 1'b1);
    expect_v("chk_bad_err", 32'd1);    check(32'(load_err));
    expect_v("chk_bad_run", 32'd0);    check(32'(cpu_run));
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
